// File: rtl/ldpc_out_pkg.sv
// Shared constants for the LDPC output path: lane count, frame lengths and frame counter sizing.
// Also holds the helpers used by out_pack for end-of-frame selection and the optional one-hot check.
package ldpc_out_pkg;

    localparam int N_LANES = 36;
    localparam int FLEN_R0 = 4608;
    localparam int FLEN_R1 = 6912;
    localparam int FCNT_W  = 13;

    localparam logic [FCNT_W-1:0] FMAX_R0 = 13'd4607;
    localparam logic [FCNT_W-1:0] FMAX_R1 = 13'd6911;

    typedef logic [N_LANES-1:0] lane_vec_t;
    typedef logic [FCNT_W-1:0]  fcnt_t;

    // Index of the last bit of a frame for the given code rate.
    function automatic fcnt_t frame_max(input logic rate_sel);
        return rate_sel ? FMAX_R1 : FMAX_R0;
    endfunction

    function automatic logic is_onehot(input lane_vec_t v);
        return (v != '0) && ((v & (v - lane_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO behind the out_pack valid/ready port.
// A push while full is accepted only if a pop happens on the same edge.
module out_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the head is masked while empty so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/out_pack.sv
// LDPC output packer: picks one codeword bit per enabled read, packs LSB-first into OW-bit words, FIFOs them.
// Build with OUT_PACK_ONEHOT_CHK_EN defined to enable the sticky rd_sel one-hot checker on sel_err.
module out_pack
    import ldpc_out_pkg::*;
#(
    parameter int OW     = 8,
    parameter int RD_LAT = 1,
    parameter int FDEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rate,
    input  logic               rd_en,
    input  logic [N_LANES-1:0] rd_sel,
    input  logic [N_LANES-1:0] mem_q,
    output logic [OW-1:0]      dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               ovf,
    output logic               sel_err
);

    localparam int BW = (OW > 1) ? $clog2(OW) : 1;

    logic [RD_LAT-1:0] en_pipe;
    lane_vec_t         sel_pipe [RD_LAT];
    logic              en_d;
    lane_vec_t         sel_d;
    logic              bit_in;

    logic [BW-1:0]     bcnt;
    logic [OW-1:0]     sh_word;
    logic [OW-1:0]     word_next;
    logic              word_full;

    fcnt_t             fcnt;
    logic              rate_l;
    logic              frame_end;

    logic              push;
    logic [OW:0]       fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // Delay rd_en/rd_sel so they line up with mem_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) sel_pipe[i] <= '0;
        end else begin
            en_pipe[0]  <= rd_en;
            sel_pipe[0] <= rd_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe[i]  <= en_pipe[i-1];
                sel_pipe[i] <= sel_pipe[i-1];
            end
        end
    end

    assign en_d   = en_pipe[RD_LAT-1];
    assign sel_d  = sel_pipe[RD_LAT-1];
    assign bit_in = |(mem_q & sel_d);

    assign word_full = (bcnt == BW'(OW - 1));
    assign frame_end = (fcnt == frame_max(rate_l));
    assign push      = en_d && word_full;

    // Completed word includes the bit captured on this edge.
    always_comb begin
        word_next       = sh_word;
        word_next[bcnt] = bit_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt    <= '0;
            sh_word <= '0;
            fcnt    <= '0;
            rate_l  <= 1'b0;
        end else if (en_d) begin
            sh_word <= word_next;
            bcnt    <= word_full ? '0 : bcnt + BW'(1);
            if (fcnt == '0) rate_l <= rate;
            fcnt    <= frame_end ? '0 : fcnt + FCNT_W'(1);
        end
    end

    // A full FIFO only accepts the push if the sink drains the head on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !dout_ready) begin
            ovf <= 1'b1;
        end
    end

`ifdef OUT_PACK_ONEHOT_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (en_d && !is_onehot(sel_d)) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

    out_fifo #(
        .WIDTH (OW + 1),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (dout_ready),
        .wdata   ({frame_end, word_next}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign dout_valid = !fifo_empty;
    assign dout       = fifo_rdata[OW-1:0];
    assign dout_last  = fifo_rdata[OW];

endmodule
